sqrt_iter_unit: RTL and testbench
=================================

Name: sqrt_iter_unit

Overview:
- Parametrised iterative integer square-root engine with its own datapath and control.
- Restoring digit-by-digit algorithm: one root bit per clock.
- Valid/ready handshake on both input and output, so it can sit between pipeline stages.
- Also reports the remainder and a perfect-square flag.

Parameters:
WIDTH, 16, radicand width in bits; must be even and >= 4.
RW, WIDTH/2, root width; derived, not overridable.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  radicand offered
in_ready  out  1  engine can accept a radicand (state IDLE)
in_radicand  in  WIDTH  unsigned radicand
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_root  out  RW  floor(sqrt(radicand))
out_rem  out  RW+1  radicand - root^2 (max value 2*root)
out_exact  out  1  1 when out_rem == 0
busy  out  1  high in ITER

Behaviour:
- Reset and clocking:
  - Reset is synchronous, active-high, on rst, clocked by clk.
  - rst wins over every other input, including mid-computation.
  - On reset: state=IDLE, in_ready=1, out_valid=0, busy=0, out_root=0, out_rem=0, out_exact=0. Counter and internal registers are cleared.
- States: IDLE, ITER, DONE (2-bit encoding). All outputs are registered or decoded from state; none depends combinationally on in_valid or out_ready.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch the radicand into shift register D, clear root R and partial remainder P (RW+2 bits), load counter with RW-1, go to ITER.
- ITER (busy=1, in_ready=0), each cycle:
  - P' = {P[RW-1:0], D[WIDTH-1:WIDTH-2]}.
  - T = {R, 2'b01}, zero-extended to RW+2 bits.
  - If P' >= T: P = P' - T and R = {R[RW-2:0], 1}.
  - Else: P = P' and R = {R[RW-2:0], 0}.
  - D shifts left by 2.
  - Counter == 0: go to DONE and load out_root=R_next, out_rem=P_next[RW:0], out_exact=(P_next==0). Otherwise decrement the counter.
- DONE:
  - out_valid=1. out_root, out_rem and out_exact are held stable.
  - On out_ready: go to IDLE, out_valid drops on the next edge.
  - A new radicand cannot be accepted in the same cycle as the result handoff (in_ready=0 in DONE).
- Latency:
  - Accept edge k puts the FSM in ITER.
  - out_valid is high after edge k+RW: 8 cycles for WIDTH=16, 4 for WIDTH=8.
  - Throughput is one result per RW+2 cycles when out_ready is held high.
- Width rules:
  - All compares and subtracts are unsigned at RW+2 bits, with no overflow.
  - out_rem fits in RW+1 bits because rem <= 2*root.
- Boundaries:
  - Radicand 0 gives root 0, rem 0, exact 1.
  - All-ones radicand gives root 2^RW-1, rem 2^(RW+1)-2.
  - in_valid during ITER or DONE is ignored; the input is not consumed.
  - out_ready while not in DONE has no effect.
  - Indefinite backpressure: DONE persists and the result is held.
  - rst asserted during ITER or DONE aborts the operation with no out_valid pulse and returns to IDLE next edge.
- Outputs: out_root, out_rem and out_exact keep their last result while in IDLE until the next completion.

Test Plan:
- WIDTH=16, in_radicand=144 accepted at edge k -> out_valid high after edge k+8, out_root=12, out_rem=0, out_exact=1, busy high exactly 8 cycles.
- WIDTH=16, radicands 150, 0, 65535 back-to-back with out_ready=1 -> results (12,6,0), (0,0,1), (255,510,0), each 10 cycles apart.
- WIDTH=16, radicand 1000, out_ready held 0 for 20 cycles then 1 -> out_valid stays high with root=31 and rem=39 stable throughout. in_ready=0 and in_valid pulses are ignored until the handshake completes, then in_ready=1 next cycle.
- WIDTH=16, rst pulsed on 4th ITER cycle of radicand 50000 -> next edge IDLE, out_valid=0, outputs 0. A following radicand 49 yields root 7, rem 0.
- WIDTH=8 instance, radicands 200 and 255 -> (14,4,0) after 4 cycles and (15,30,0). Exhaustive sweep 0..255 compared against a reference model.

Source files
------------

// File: rtl/sqrt_iter_unit.sv
// Iterative restoring integer square root, one root bit per clock; result valid RW cycles after accept.
// Backpressure: the result is held in DONE until out_ready; no new radicand is taken until then.
module sqrt_iter_unit #(
  parameter int WIDTH = 16,
  localparam int RW = WIDTH / 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_radicand,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RW-1:0]     out_root,
  output logic [RW:0]       out_rem,
  output logic              out_exact,
  output logic              busy
);

  localparam int CW = (RW > 1) ? $clog2(RW) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] d;
  logic [RW-1:0]    r;
  // Between steps the partial remainder is below 2^RW, so only its low RW bits need storing.
  logic [RW-1:0]    p;
  logic [CW-1:0]    cnt;

  logic [RW+1:0]    p_shift;
  logic [RW+1:0]    t_val;
  logic [RW+1:0]    p_next;
  logic [RW-1:0]    r_next;

  always_comb begin
    p_shift = {p, d[WIDTH-1:WIDTH-2]};
    t_val   = {r, 2'b01};
    p_next  = p_shift;
    r_next  = {r[RW-2:0], 1'b0};
    if (p_shift >= t_val) begin
      p_next = p_shift - t_val;
      r_next = {r[RW-2:0], 1'b1};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_ITER;
      S_ITER:  if (cnt == '0) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      d         <= '0;
      r         <= '0;
      p         <= '0;
      cnt       <= '0;
      out_root  <= '0;
      out_rem   <= '0;
      out_exact <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            d   <= in_radicand;
            r   <= '0;
            p   <= '0;
            cnt <= CW'(RW - 1);
          end
        end
        S_ITER: begin
          d   <= {d[WIDTH-3:0], 2'b00};
          r   <= r_next;
          p   <= p_next[RW-1:0];
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            out_root  <= r_next;
            out_rem   <= p_next[RW:0];
            out_exact <= (p_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_ITER);

endmodule

// File: tb/tb_sqrt_iter_unit.sv
// Scoreboard bench for sqrt_iter_unit: a 16-bit and an 8-bit instance checked against an
// independent brute-force square-root model.
module tb_sqrt_iter_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, exact16, busy16;
  logic [15:0] rad16;
  logic [7:0]  root16;
  logic [8:0]  rem16;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, exact8, busy8;
  logic [7:0]  rad8;
  logic [3:0]  root8;
  logic [4:0]  rem8;

  sqrt_iter_unit #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_radicand(rad16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .out_root(root16), .out_rem(rem16), .out_exact(exact16), .busy(busy16)
  );

  sqrt_iter_unit #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_radicand(rad8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_root(root8), .out_rem(rem8), .out_exact(exact8), .busy(busy8)
  );

  typedef struct {
    int root;
    int rem;
    int exact;
  } res_t;

  res_t q16[$];
  res_t q8[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic res_t ref_sqrt(input int v);
    res_t e;
    int rt = 0;
    while ((rt + 1) * (rt + 1) <= v) rt++;
    e.root  = rt;
    e.rem   = v - rt * rt;
    e.exact = (e.rem == 0) ? 1 : 0;
    return e;
  endfunction

  // Result monitors: compare at the handshake, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst && out_valid16 && out_ready16) begin
      chk("q16_pending", (q16.size() != 0), 1);
      if (q16.size() != 0) begin
        res_t e;
        e = q16.pop_front();
        chk("root16", root16, e.root);
        chk("rem16", rem16, e.rem);
        chk("exact16", exact16, e.exact);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid8 && out_ready8) begin
      chk("q8_pending", (q8.size() != 0), 1);
      if (q8.size() != 0) begin
        res_t e;
        e = q8.pop_front();
        chk("root8", root8, e.root);
        chk("rem8", rem8, e.rem);
        chk("exact8", exact8, e.exact);
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send16(input logic [15:0] v, output int acc);
    int n = 0;
    in_valid16 = 1'b1;
    rad16 = v;
    @(negedge clk);
    while (!in_ready16 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept16_timeout", n, 0);
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid16 = 1'b0;
    q16.push_back(ref_sqrt(int'(v)));
  endtask

  task automatic send8(input logic [7:0] v, output int acc);
    int n = 0;
    in_valid8 = 1'b1;
    rad8 = v;
    @(negedge clk);
    while (!in_ready8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept8_timeout", n, 0);
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid8 = 1'b0;
    q8.push_back(ref_sqrt(int'(v)));
  endtask

  task automatic drain();
    int n = 0;
    while ((q16.size() != 0 || q8.size() != 0) && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", q16.size() + q8.size(), 0);
  endtask

  initial begin
    int a0, a1, a2, n, bcnt;
    logic stable;

    rst = 1'b1;
    in_valid16 = 1'b0; rad16 = '0; out_ready16 = 1'b0;
    in_valid8 = 1'b0;  rad8 = '0;  out_ready8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_in_ready", in_ready16, 1);
    chk("rst_out_valid", out_valid16, 0);
    chk("rst_busy", busy16, 0);
    chk("rst_root", root16, 0);
    chk("rst_rem", rem16, 0);
    chk("rst_exact", exact16, 0);
    chk("rst_in_ready8", in_ready8, 1);

    // 144: latency and busy duration
    send16(16'd144, a0);
    n = 0;
    bcnt = busy16 ? 1 : 0;
    while (!out_valid16 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
      if (busy16) bcnt++;
    end
    chk("lat16", n, 8);
    chk("busy16_cycles", bcnt, 8);
    out_ready16 = 1'b1;
    @(posedge clk);
    #1;
    chk("handoff_out_valid", out_valid16, 0);
    chk("handoff_in_ready", in_ready16, 1);

    // back-to-back throughput
    send16(16'd150, a0);
    send16(16'd0, a1);
    send16(16'd65535, a2);
    chk("gap01", a1 - a0, 10);
    chk("gap12", a2 - a1, 10);
    drain();

    // indefinite backpressure with ignored input offers
    out_ready16 = 1'b0;
    send16(16'd1000, a0);
    n = 0;
    while (!out_valid16 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_valid", out_valid16, 1);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5 || i == 12) begin
        in_valid16 = 1'b1;
        rad16 = 16'd4;
      end else begin
        in_valid16 = 1'b0;
      end
      @(posedge clk);
      #1;
      if (!(out_valid16 && root16 == 8'd31 && rem16 == 9'd39 && !in_ready16 && !busy16))
        stable = 1'b0;
    end
    in_valid16 = 1'b0;
    chk("bp_hold_stable", stable, 1);
    out_ready16 = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", out_valid16, 0);
    chk("bp_release_ready", in_ready16, 1);
    chk("bp_release_busy", busy16, 0);
    drain();

    // reset in the 4th ITER cycle aborts
    send16(16'd50000, a0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(q16.pop_back());
    chk("abort_in_ready", in_ready16, 1);
    chk("abort_out_valid", out_valid16, 0);
    chk("abort_busy", busy16, 0);
    chk("abort_root", root16, 0);
    chk("abort_rem", rem16, 0);
    chk("abort_exact", exact16, 0);
    send16(16'd49, a0);
    drain();

    // 8-bit instance: latency, corners, exhaustive sweep
    send8(8'd200, a0);
    n = 0;
    while (!out_valid8 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("lat8", n, 4);
    out_ready8 = 1'b1;
    send8(8'd255, a0);
    drain();
    for (int v = 0; v < 256; v++) send8(8'(v), a0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
